// File: rtl/mul_real_pipe.sv
// rtl/mul_real_pipe.sv - pipelined fixed-point real multiplier with valid/ready flow control
// Stage 1 registers the full-precision product; the last stage aligns, clamps or wraps, and registers c.
module mul_real_pipe #(
  parameter int WIDTH_A  = 16,
  parameter int EXP_A    = -12,
  parameter int WIDTH_B  = 16,
  parameter int EXP_B    = -12,
  parameter int WIDTH_C  = 16,
  parameter int EXP_C    = -12,
  parameter int LATENCY  = 2,
  parameter int SATURATE = 1
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic signed [WIDTH_A-1:0] a,
  input  logic signed [WIDTH_B-1:0] b,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic signed [WIDTH_C-1:0] c,
  output logic                      ovf,
  output logic                      ovf_sticky
);

  localparam int PW  = WIDTH_A + WIDTH_B;
  localparam int D   = EXP_A + EXP_B - EXP_C;
  localparam int DL  = (D > 0) ? D : 0;
  localparam int DR  = (D < 0) ? -D : 0;
  localparam int EW0 = PW + DL;
  // One guard bit beyond the widest of product-after-left-shift and output keeps range compares exact.
  localparam int EW  = ((EW0 > WIDTH_C) ? EW0 : WIDTH_C) + 1;

  localparam logic signed [EW-1:0] MAX_V = {{(EW-WIDTH_C+1){1'b0}}, {(WIDTH_C-1){1'b1}}};
  localparam logic signed [EW-1:0] MIN_V = ~MAX_V;

  logic advance;
  assign advance  = !out_valid || out_ready;
  assign in_ready = advance;

  logic signed [PW-1:0] a_ext, b_ext, prod_now;
  assign a_ext    = a;
  assign b_ext    = b;
  assign prod_now = a_ext * b_ext;

  logic signed [PW-1:0] fin_prod;
  logic                 fin_valid;

  generate
    if (LATENCY == 1) begin : g_lat1
      assign fin_prod  = prod_now;
      assign fin_valid = in_valid;
    end else begin : g_latn
      logic signed [PW-1:0] p_q [LATENCY-1];
      logic [LATENCY-2:0]   v_q;

      always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
          for (int i = 0; i < LATENCY-1; i++) p_q[i] <= '0;
          v_q <= '0;
        end else if (advance) begin
          p_q[0] <= prod_now;
          v_q[0] <= in_valid;
          for (int i = 1; i < LATENCY-1; i++) begin
            p_q[i] <= p_q[i-1];
            v_q[i] <= v_q[i-1];
          end
        end
      end

      assign fin_prod  = p_q[LATENCY-2];
      assign fin_valid = v_q[LATENCY-2];
    end
  endgenerate

  logic signed [EW-1:0]      ext, aligned;
  logic                      ovf_now;
  logic signed [WIDTH_C-1:0] c_now;

  assign ext     = {{(EW-PW){fin_prod[PW-1]}}, fin_prod};
  // Arithmetic right shift floors toward negative infinity, which is the required truncation.
  assign aligned = (ext <<< DL) >>> DR;
  assign ovf_now = (aligned > MAX_V) || (aligned < MIN_V);

  always_comb begin
    c_now = aligned[WIDTH_C-1:0];
    if (ovf_now && (SATURATE != 0))
      c_now = aligned[EW-1] ? {1'b1, {(WIDTH_C-1){1'b0}}} : {1'b0, {(WIDTH_C-1){1'b1}}};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid  <= 1'b0;
      c          <= '0;
      ovf        <= 1'b0;
      ovf_sticky <= 1'b0;
    end else if (advance) begin
      out_valid <= fin_valid;
      if (fin_valid) begin
        c   <= c_now;
        ovf <= ovf_now;
        if (ovf_now) ovf_sticky <= 1'b1;
      end
    end
  end

endmodule
